receiver_scan: RTL and testbench

RECEIVER_SCAN -- requirements
Module: receiver_scan

---
 rtl/receiver_scan.sv | 192 +++++++++++++++++++
 tb/tb_receiver_scan.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/receiver_scan.sv
// receiver_scan: scans the 16 incoming ray/knight channels of one square and emits each legal move into that square.
// Ports: clk, rst_n (sync, active-low); engine_color, sq_pos, sq_reg and sample latch a scan request.
//        U..DR carry ray messages and UUL..RRD carry knight messages. mv_* is a valid/ready move stream; busy, done and mv_count report scan status.
module receiver_scan (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        engine_color,
  input  logic [5:0]  sq_pos,
  input  logic [5:0]  sq_reg,
  input  logic        sample,
  input  logic [10:0] U,
  input  logic [10:0] D,
  input  logic [10:0] L,
  input  logic [10:0] R,
  input  logic [10:0] UL,
  input  logic [10:0] UR,
  input  logic [10:0] DL,
  input  logic [10:0] DR,
  input  logic [7:0]  UUL,
  input  logic [7:0]  UUR,
  input  logic [7:0]  LLU,
  input  logic [7:0]  RRU,
  input  logic [7:0]  DDL,
  input  logic [7:0]  DDR,
  input  logic [7:0]  LLD,
  input  logic [7:0]  RRD,
  output logic        mv_valid,
  input  logic        mv_ready,
  output logic [5:0]  mv_src,
  output logic [5:0]  mv_dst,
  output logic [4:0]  mv_piece,
  output logic        mv_capture,
  output logic        busy,
  output logic        done,
  output logic [4:0]  mv_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [4:0] T_PAWN   = 5'b00010;
  localparam logic [4:0] T_KNIGHT = 5'b00001;
  localparam logic [4:0] T_BISHOP = 5'b01000;
  localparam logic [4:0] T_ROOK   = 5'b10000;
  localparam logic [4:0] T_QUEEN  = 5'b11000;
  localparam logic [4:0] T_KING   = 5'b00100;

  logic [1:0]        state;
  logic [3:0]        idx;
  logic              color_q;
  logic [5:0]        pos_q;
  logic [5:0]        occ_q;
  logic [7:0][10:0]  ray_q;
  logic [7:0][7:0]   kn_q;

  // Snapshot of the request; only taken in IDLE so later input changes cannot disturb a scan.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && sample) begin
      color_q <= engine_color;
      pos_q   <= sq_pos;
      occ_q   <= sq_reg;
      ray_q   <= {DR, DL, UR, UL, R, L, D, U};
      kn_q    <= {RRD, LLD, DDR, DDL, RRU, LLU, UUR, UUL};
    end
  end

  // The reserved bit of the knight messages carries no information.
  logic unused_rsvd;
  assign unused_rsvd = ^{kn_q[0][6], kn_q[1][6], kn_q[2][6], kn_q[3][6],
                         kn_q[4][6], kn_q[5][6], kn_q[6][6], kn_q[7][6]};

  // Current channel decode: idx 0-7 are rays, 8-15 are knight channels.
  logic        is_knight;
  logic [10:0] cur_ray;
  logic [7:0]  cur_kn;
  logic [5:0]  src;
  logic [4:0]  rtype;
  logic        dst_occ;
  logic        dst_own;
  logic        dst_opp;
  logic signed [3:0] drank;
  logic signed [3:0] dfile;
  logic [3:0]  adr;
  logic [3:0]  adf;
  logic signed [3:0] step;
  logic        king_ok;
  logic        pawn_ok;
  logic        pawn_fwd;
  logic        pawn_diag;
  logic [2:0]  home_rank;
  logic        ray_ok;
  logic        legal;
  logic [4:0]  piece;

  assign is_knight = idx[3];
  assign cur_ray   = ray_q[idx[2:0]];
  assign cur_kn    = kn_q[idx[2:0]];
  assign src       = is_knight ? cur_kn[5:0] : cur_ray[10:5];
  assign rtype     = cur_ray[4:0];

  assign dst_occ = (occ_q[4:0] != 5'd0);
  assign dst_own = dst_occ && (occ_q[5] == color_q);
  assign dst_opp = dst_occ && (occ_q[5] != color_q);

  assign drank = $signed({1'b0, pos_q[5:3]}) - $signed({1'b0, src[5:3]});
  assign dfile = $signed({1'b0, pos_q[2:0]}) - $signed({1'b0, src[2:0]});
  assign adr   = drank[3] ? 4'(-drank) : 4'(drank);
  assign adf   = dfile[3] ? 4'(-dfile) : 4'(dfile);

  // Chebyshev distance of exactly one.
  assign king_ok = (adr <= 4'd1) && (adf <= 4'd1) && ((adr == 4'd1) || (adf == 4'd1));

  // Pawn rules written once in "forward" terms; BLACK flips the rank delta.
  assign step      = color_q ? drank : 4'(-drank);
  assign home_rank = color_q ? 3'd1 : 3'd6;
  assign pawn_fwd  = color_q ? (idx == 4'd0) : (idx == 4'd1);
  assign pawn_diag = color_q ? ((idx == 4'd4) || (idx == 4'd5))
                             : ((idx == 4'd6) || (idx == 4'd7));
  assign pawn_ok   = (pawn_fwd && !dst_occ &&
                      ((step == 4'sd1) || ((step == 4'sd2) && (src[5:3] == home_rank)))) ||
                     (pawn_diag && (step == 4'sd1) && dst_opp);

  always_comb begin
    ray_ok = 1'b0;
    case (rtype)
      T_ROOK:   ray_ok = (idx[2] == 1'b0);
      T_BISHOP: ray_ok = (idx[2] == 1'b1);
      T_QUEEN:  ray_ok = 1'b1;
      T_KING:   ray_ok = king_ok;
      T_PAWN:   ray_ok = pawn_ok;
      default:  ray_ok = 1'b0;
    endcase
  end

  assign legal = !dst_own && (is_knight ? cur_kn[7] : ((rtype != 5'd0) && ray_ok));
  assign piece = is_knight ? T_KNIGHT : rtype;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      mv_count   <= 5'd0;
      mv_src     <= 6'd0;
      mv_dst     <= 6'd0;
      mv_piece   <= 5'd0;
      mv_capture <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sample) begin
            idx      <= 4'd0;
            mv_count <= 5'd0;
            state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (legal) begin
            mv_src     <= src;
            mv_dst     <= pos_q;
            mv_piece   <= piece;
            mv_capture <= dst_opp;
            state      <= S_EMIT;
          end else if (idx == 4'd15) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_EMIT: begin
          // Move record is frozen here until the consumer takes it.
          if (mv_ready) begin
            mv_count <= mv_count + 5'd1;
            if (idx == 4'd15) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 4'd1;
              state <= S_SCAN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mv_valid = (state == S_EMIT);
  assign busy     = (state == S_SCAN) || (state == S_EMIT);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_receiver_scan.sv
// tb_receiver_scan: directed vectors for receiver_scan plus hold, ignored-sample and reset sequences.
// Drives and samples on the falling clock edge; prints one summary line.
module tb_receiver_scan;

  localparam logic [4:0] P  = 5'b00010;
  localparam logic [4:0] N  = 5'b00001;
  localparam logic [4:0] B  = 5'b01000;
  localparam logic [4:0] RK = 5'b10000;
  localparam logic [4:0] Q  = 5'b11000;
  localparam logic [4:0] K  = 5'b00100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic color = 1'b1;
  logic [5:0] pos = '0;
  logic [5:0] occ = '0;
  logic sample = 1'b0;
  logic [7:0][10:0] ray_in = '0;
  logic [7:0][7:0] kn_in = '0;
  logic mv_ready = 1'b0;
  logic mv_valid, mv_capture, busy, done;
  logic [5:0] mv_src, mv_dst;
  logic [4:0] mv_piece, mv_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  receiver_scan dut (
    .clk(clk), .rst_n(rst_n), .engine_color(color), .sq_pos(pos), .sq_reg(occ), .sample(sample),
    .U(ray_in[0]), .D(ray_in[1]), .L(ray_in[2]), .R(ray_in[3]),
    .UL(ray_in[4]), .UR(ray_in[5]), .DL(ray_in[6]), .DR(ray_in[7]),
    .UUL(kn_in[0]), .UUR(kn_in[1]), .LLU(kn_in[2]), .RRU(kn_in[3]),
    .DDL(kn_in[4]), .DDR(kn_in[5]), .LLD(kn_in[6]), .RRD(kn_in[7]),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_src(mv_src), .mv_dst(mv_dst),
    .mv_piece(mv_piece), .mv_capture(mv_capture), .busy(busy), .done(done), .mv_count(mv_count)
  );

  typedef struct packed {
    logic             color;
    logic [5:0]       pos;
    logic [5:0]       occ;
    logic [7:0][10:0] ray;
    logic [7:0][7:0]  kn;
    logic [1:0]       n;
    logic [1:0][5:0]  e_src;
    logic [1:0][4:0]  e_pc;
    logic [1:0]       e_cap;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    color  = v.color;
    pos    = v.pos;
    occ    = v.occ;
    ray_in = v.ray;
    kn_in  = v.kn;
  endtask

  // Garbage after the latch: an unlatched design would see no moves and a wrong square.
  task automatic scramble(input vec_t v);
    pos    = ~v.pos;
    occ    = {v.color, 5'b10000};
    ray_in = '0;
    kn_in  = '0;
  endtask

  // Cycle 1 is the cycle sample is high; with the consumer always ready, done lands in cycle 18 + moves.
  task automatic run_vec(input vec_t v, input int id);
    int got;
    int cyc;
    int done_cyc;
    got = 0;
    done_cyc = 0;
    @(negedge clk);
    apply(v);
    sample = 1'b1;
    mv_ready = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    scramble(v);
    cyc = 2;
    chk($sformatf("v%0d busy", id), {31'd0, busy}, 32'd1);
    while (done_cyc == 0 && cyc < 60) begin
      if (mv_valid) begin
        if (got < 2 && got < int'(v.n)) begin
          chk($sformatf("v%0d mv%0d src", id, got), {26'd0, mv_src}, {26'd0, v.e_src[got]});
          chk($sformatf("v%0d mv%0d piece", id, got), {27'd0, mv_piece}, {27'd0, v.e_pc[got]});
          chk($sformatf("v%0d mv%0d cap", id, got), {31'd0, mv_capture}, {31'd0, v.e_cap[got]});
          chk($sformatf("v%0d mv%0d dst", id, got), {26'd0, mv_dst}, {26'd0, v.pos});
        end
        got++;
      end
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("v%0d mv_count", id), {27'd0, mv_count}, {30'd0, v.n});
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("v%0d moves", id), got, {30'd0, v.n});
    chk($sformatf("v%0d done_cycle", id), done_cyc, 18 + int'(v.n));
    chk($sformatf("v%0d done_pulse", id), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d idle_busy", id), {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_valid(input string nm);
    int cnt;
    cnt = 0;
    while (!mv_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk(nm, {31'd0, mv_valid}, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int cnt;
    cnt = 0;
    while (!done && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk(nm, {31'd0, done}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) vecs[i] = '0;
    // WHITE single push rank1 -> rank2.
    vecs[0].color = 1'b1; vecs[0].pos = 6'b010010;
    vecs[0].ray[0] = {6'b001010, P};
    vecs[0].n = 2'd1; vecs[0].e_src[0] = 6'b001010; vecs[0].e_pc[0] = P;
    // Bishop capture then knight capture on a black rook.
    vecs[1].color = 1'b1; vecs[1].pos = 6'b011011; vecs[1].occ = {1'b0, RK};
    vecs[1].ray[4] = {6'b010100, B}; vecs[1].kn[0] = 8'b1_0_001100;
    vecs[1].n = 2'd2; vecs[1].e_src = {6'b001100, 6'b010100};
    vecs[1].e_pc = {N, B}; vecs[1].e_cap = 2'b11;
    // Own piece on the square blocks every channel.
    vecs[2].color = 1'b1; vecs[2].pos = 6'b011011; vecs[2].occ = {1'b1, RK};
    for (int i = 0; i < 8; i++) begin
      vecs[2].ray[i] = {6'(i), Q};
      vecs[2].kn[i]  = {2'b10, 6'(i + 8)};
    end
    // King two ranks away on U, rook on a diagonal.
    vecs[3].color = 1'b1; vecs[3].pos = 6'b011011;
    vecs[3].ray[0] = {6'b001011, K}; vecs[3].ray[4] = {6'b010100, RK};
    // Pawn double step from rank 1, king one diagonal step on DR.
    vecs[4].color = 1'b1; vecs[4].pos = 6'b011011;
    vecs[4].ray[0] = {6'b001011, P}; vecs[4].ray[7] = {6'b100010, K};
    vecs[4].n = 2'd2; vecs[4].e_src = {6'b100010, 6'b001011}; vecs[4].e_pc = {K, P};
    // BLACK: blocked push, diagonal pawn capture, rook capture, pawn on the wrong ray.
    vecs[5].color = 1'b0; vecs[5].pos = 6'b011011; vecs[5].occ = {1'b1, N};
    vecs[5].ray[0] = {6'b010011, P}; vecs[5].ray[1] = {6'b100011, P};
    vecs[5].ray[3] = {6'b011000, RK}; vecs[5].ray[6] = {6'b100100, P};
    vecs[5].n = 2'd2; vecs[5].e_src = {6'b100100, 6'b011000};
    vecs[5].e_pc = {P, RK}; vecs[5].e_cap = 2'b11;
    // Bishop on U and knight-type on L illegal; queen on DR, valid RRD knight; UUL not valid.
    vecs[6].color = 1'b1; vecs[6].pos = 6'b100100;
    vecs[6].ray[0] = {6'b011100, B}; vecs[6].ray[2] = {6'b100110, N};
    vecs[6].ray[7] = {6'b101011, Q}; vecs[6].kn[0] = 8'b0_0_101010;
    vecs[6].kn[7] = 8'b1_0_101010;
    vecs[6].n = 2'd2; vecs[6].e_src = {6'b101010, 6'b101011}; vecs[6].e_pc = {N, Q};
    // Double step from rank 2, diagonal pawn onto an empty square: both illegal.
    vecs[7].color = 1'b1; vecs[7].pos = 6'b100011;
    vecs[7].ray[0] = {6'b010011, P}; vecs[7].ray[5] = {6'b011010, P};
    // Rook from square 0 (all-zero source is still a message).
    vecs[8].color = 1'b1; vecs[8].pos = 6'b010000;
    vecs[8].ray[0] = {6'b000000, RK};
    vecs[8].n = 2'd1; vecs[8].e_src[0] = 6'b000000; vecs[8].e_pc[0] = RK;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst mv_valid", {31'd0, mv_valid}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst mv_count", {27'd0, mv_count}, 32'd0);
    chk("rst mv_src", {26'd0, mv_src}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Consumer stalls five cycles; a sample pulse in the middle must be ignored.
    @(negedge clk);
    apply(vecs[0]); mv_ready = 1'b0; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0; scramble(vecs[0]);
    wait_valid("hold seen");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold%0d valid", k), {31'd0, mv_valid}, 32'd1);
      chk($sformatf("hold%0d src", k), {26'd0, mv_src}, 32'b001010);
      chk($sformatf("hold%0d dst", k), {26'd0, mv_dst}, 32'b010010);
      chk($sformatf("hold%0d piece", k), {27'd0, mv_piece}, {27'd0, P});
      chk($sformatf("hold%0d cap", k), {31'd0, mv_capture}, 32'd0);
      sample = (k == 2);
      if (k == 2) apply(vecs[1]);
      @(negedge clk);
    end
    sample = 1'b0;
    mv_ready = 1'b1;
    chk("hold6 valid", {31'd0, mv_valid}, 32'd1);
    chk("hold6 src", {26'd0, mv_src}, 32'b001010);
    @(negedge clk);
    mv_ready = 1'b0;
    chk("accept valid", {31'd0, mv_valid}, 32'd0);
    chk("accept count", {27'd0, mv_count}, 32'd1);
    wait_done("hold done");
    chk("hold final count", {27'd0, mv_count}, 32'd1);

    // Reset while the second move of a scan is pending.
    @(negedge clk);
    apply(vecs[1]); mv_ready = 1'b0; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    wait_valid("rst first valid");
    mv_ready = 1'b1;
    @(negedge clk);
    mv_ready = 1'b0;
    wait_valid("rst second valid");
    chk("rst pre count", {27'd0, mv_count}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("emit rst valid", {31'd0, mv_valid}, 32'd0);
    chk("emit rst busy", {31'd0, busy}, 32'd0);
    chk("emit rst done", {31'd0, done}, 32'd0);
    chk("emit rst count", {27'd0, mv_count}, 32'd0);
    chk("emit rst src", {26'd0, mv_src}, 32'd0);
    chk("emit rst piece", {27'd0, mv_piece}, 32'd0);
    chk("emit rst cap", {31'd0, mv_capture}, 32'd0);
    run_vec(vecs[1], 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
